// File: rtl/updown_range_counter.sv
// ---------------------------------------------------------------------------
// updown_range_counter
//
// Purpose:
//   General-purpose up/down setpoint counter over the closed range
//   [MIN_VAL, MAX_VAL]. Supports a variable step, wrap or saturate behaviour
//   at the range ends, a parallel load with clamping, and registered
//   boundary/event flags. Used as the frequency/duty setpoint counter of the
//   square-wave generator front end, driven by button-decoded strobes.
//
// Parameters:
//   WIDTH      counter width in bits
//   MIN_VAL    lowest legal count
//   MAX_VAL    highest legal count (MIN_VAL < MAX_VAL < 2**WIDTH)
//   RESET_VAL  value taken on reset (MIN_VAL <= RESET_VAL <= MAX_VAL)
//   STEP_W     width of the step input
//
// Ports:
//   clk         in   single clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   en          in   count enable (does not gate load)
//   up          in   increment request (level sampled)
//   down        in   decrement request (level sampled)
//   step        in   increment/decrement magnitude
//   wrap_mode   in   1 = wrap within range, 0 = saturate at range ends
//   load        in   parallel load strobe
//   load_val    in   value to load (clamped into range)
//   result      out  current count, registered
//   at_min      out  result == MIN_VAL, registered
//   at_max      out  result == MAX_VAL, registered
//   wrap_pulse  out  one-cycle pulse, last update wrapped
//   sat_pulse   out  one-cycle pulse, last update clipped (saturation/clamp)
// ---------------------------------------------------------------------------
module updown_range_counter #(
    parameter int unsigned WIDTH     = 11,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 2000,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned STEP_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              wrap_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  result,
    output logic              at_min,
    output logic              at_max,
    output logic              wrap_pulse,
    output logic              sat_pulse
);

    // Arithmetic width: one bit wider than both the counter and the step so
    // that result+step, result+range and the range itself never overflow.
    localparam int unsigned AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

    localparam logic [AW-1:0]    MIN_A   = AW'(MIN_VAL);
    localparam logic [AW-1:0]    MAX_A   = AW'(MAX_VAL);
    localparam logic [AW-1:0]    RANGE_A = AW'(MAX_VAL - MIN_VAL + 1);

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic [AW-1:0]    cur_a;
    logic [AW-1:0]    step_a;
    logic [AW-1:0]    load_a;
    logic [AW-1:0]    eff_step;
    logic [AW-1:0]    up_sum;
    logic [AW-1:0]    down_room;
    logic             count_req;
    logic             load_below;
    logic             load_above;

    logic [WIDTH-1:0] next_result;
    logic             next_wrap;
    logic             next_sat;

    // Zero-extended operands so every comparison below is done at AW bits.
    assign cur_a  = AW'(result);
    assign step_a = AW'(step);
    assign load_a = AW'(load_val);

    // A step larger than the whole range is limited to the range size, so a
    // wrapping move lands back inside [MIN_VAL, MAX_VAL] after one correction.
    assign eff_step = (step_a > RANGE_A) ? RANGE_A : step_a;

    assign up_sum    = cur_a + eff_step;
    assign down_room = cur_a - MIN_A;

    // Opposing requests cancel; only a single clean direction counts.
    assign count_req = en & (up ^ down);

    // "load_val < MIN" written as "load_val + 1 <= MIN" so that a zero MIN
    // does not turn this into an always-false unsigned comparison.
    assign load_below = ((load_a + AW'(1)) <= MIN_A);
    assign load_above = (load_a > MAX_A);

    // Next-state selection: load has priority over counting; with a zero
    // effective step nothing moves and no pulse is raised.
    always_comb begin
        next_result = result;
        next_wrap   = 1'b0;
        next_sat    = 1'b0;

        if (load) begin
            if (load_below) begin
                next_result = MIN_W;
                next_sat    = 1'b1;
            end else if (load_above) begin
                next_result = MAX_W;
                next_sat    = 1'b1;
            end else begin
                next_result = load_val;
            end
        end else if (count_req && (eff_step != '0)) begin
            if (up) begin
                if (up_sum <= MAX_A) begin
                    next_result = WIDTH'(up_sum);
                end else if (wrap_mode) begin
                    next_result = WIDTH'(up_sum - RANGE_A);
                    next_wrap   = 1'b1;
                end else begin
                    next_result = MAX_W;
                    next_sat    = 1'b1;
                end
            end else begin
                if (down_room >= eff_step) begin
                    next_result = WIDTH'(cur_a - eff_step);
                end else if (wrap_mode) begin
                    // Add the range before subtracting so the value never
                    // goes negative.
                    next_result = WIDTH'(cur_a + RANGE_A - eff_step);
                    next_wrap   = 1'b1;
                end else begin
                    next_result = MIN_W;
                    next_sat    = 1'b1;
                end
            end
        end
    end

    // Output register. Boundary flags are derived from the value being
    // written so they always agree with result in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            result     <= RESET_W;
            at_min     <= (RESET_W == MIN_W);
            at_max     <= (RESET_W == MAX_W);
            wrap_pulse <= 1'b0;
            sat_pulse  <= 1'b0;
        end else begin
            result     <= next_result;
            at_min     <= (next_result == MIN_W);
            at_max     <= (next_result == MAX_W);
            wrap_pulse <= next_wrap;
            sat_pulse  <= next_sat;
        end
    end

endmodule

// File: tb/tb_updown_range_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_range_counter
//
// Self-checking bench for updown_range_counter. Two instances share all
// inputs: one with the default range [0, 2000] and one with a narrow range
// [10, 20], which makes step clamping and wrap-to-self reachable. Each
// instance is tracked by a behavioural model based on modular arithmetic.
// ---------------------------------------------------------------------------
module tb_updown_range_counter;

    typedef struct {
        int result;
        bit wrap;
        bit sat;
    } model_t;

    localparam int LO1 = 0;
    localparam int HI1 = 2000;
    localparam int RV1 = 0;
    localparam int LO2 = 10;
    localparam int HI2 = 20;
    localparam int RV2 = 10;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        down;
    logic [3:0]  step;
    logic        wrap_mode;
    logic        load;
    logic [10:0] load_val;

    logic [10:0] result1;
    logic        at_min1;
    logic        at_max1;
    logic        wrap_pulse1;
    logic        sat_pulse1;

    logic [10:0] result2;
    logic        at_min2;
    logic        at_max2;
    logic        wrap_pulse2;
    logic        sat_pulse2;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    model_t m1;
    model_t m2;

    updown_range_counter dut1 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
        .down       (down),
        .step       (step),
        .wrap_mode  (wrap_mode),
        .load       (load),
        .load_val   (load_val),
        .result     (result1),
        .at_min     (at_min1),
        .at_max     (at_max1),
        .wrap_pulse (wrap_pulse1),
        .sat_pulse  (sat_pulse1)
    );

    updown_range_counter #(
        .WIDTH     (11),
        .MIN_VAL   (LO2),
        .MAX_VAL   (HI2),
        .RESET_VAL (RV2),
        .STEP_W    (4)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up         (up),
        .down       (down),
        .step       (step),
        .wrap_mode  (wrap_mode),
        .load       (load),
        .load_val   (load_val),
        .result     (result2),
        .at_min     (at_min2),
        .at_max     (at_max2),
        .wrap_pulse (wrap_pulse2),
        .sat_pulse  (sat_pulse2)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: positions are treated as offsets within a ring of
    // size R for wrapping, and as plain clipped arithmetic for saturation.
    function automatic model_t refNext(model_t cur, int lo, int hi, int rv,
                                       bit rst, bit ld, int lv, bit e,
                                       bit u, bit d, int st, bit wm);
        model_t n;
        int rng;
        int s;
        int raw;
        n      = cur;
        n.wrap = 1'b0;
        n.sat  = 1'b0;
        rng    = hi - lo + 1;
        if (rst) begin
            n.result = rv;
        end else if (ld) begin
            if (lv < lo) begin
                n.result = lo;
                n.sat    = 1'b1;
            end else if (lv > hi) begin
                n.result = hi;
                n.sat    = 1'b1;
            end else begin
                n.result = lv;
            end
        end else if (e && (u != d)) begin
            s = (st < rng) ? st : rng;
            if (s > 0) begin
                raw = u ? (cur.result + s) : (cur.result - s);
                if (raw >= lo && raw <= hi) begin
                    n.result = raw;
                end else if (wm) begin
                    n.result = lo + (((raw - lo) % rng) + rng) % rng;
                    n.wrap   = 1'b1;
                end else begin
                    n.result = u ? hi : lo;
                    n.sat    = 1'b1;
                end
            end
        end
        return n;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed,
                               input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): observed %0d, expected %0d",
                     tag, cycle, observed, expected);
        end
    endtask

    // Compares both instances against their models.
    task automatic compareModels();
        checkOutput("d1.result", int'(result1), m1.result);
        checkOutput("d1.at_min", int'(at_min1), int'(m1.result == LO1));
        checkOutput("d1.at_max", int'(at_max1), int'(m1.result == HI1));
        checkOutput("d1.wrap",   int'(wrap_pulse1), int'(m1.wrap));
        checkOutput("d1.sat",    int'(sat_pulse1), int'(m1.sat));
        checkOutput("d2.result", int'(result2), m2.result);
        checkOutput("d2.at_min", int'(at_min2), int'(m2.result == LO2));
        checkOutput("d2.at_max", int'(at_max2), int'(m2.result == HI2));
        checkOutput("d2.wrap",   int'(wrap_pulse2), int'(m2.wrap));
        checkOutput("d2.sat",    int'(sat_pulse2), int'(m2.sat));
    endtask

    // Drives one cycle of inputs on the falling edge, advances the models on
    // the rising edge, and checks the outputs shortly after it.
    task automatic applyStimulus(input bit rst, input bit ld, input int lv,
                                 input bit e, input bit u, input bit d,
                                 input int st, input bit wm);
        @(negedge clk);
        reset     = rst;
        load      = ld;
        load_val  = 11'(lv);
        en        = e;
        up        = u;
        down      = d;
        step      = 4'(st);
        wrap_mode = wm;
        @(posedge clk);
        m1 = refNext(m1, LO1, HI1, RV1, rst, ld, lv, e, u, d, st, wm);
        m2 = refNext(m2, LO2, HI2, RV2, rst, ld, lv, e, u, d, st, wm);
        cycle++;
        #1;
        compareModels();
    endtask

    initial begin : stimulus
        int lv;
        bit rst;
        bit ld;
        m1        = '{result: 0, wrap: 1'b0, sat: 1'b0};
        m2        = '{result: 0, wrap: 1'b0, sat: 1'b0};
        reset     = 1'b1;
        en        = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        step      = 4'd0;
        wrap_mode = 1'b0;
        load      = 1'b0;
        load_val  = 11'd0;

        $display("[TB] reset state");
        //                rst ld lv   en up dn st wm
        applyStimulus(1, 0, 0,    0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0,    0, 0, 0, 0, 0);
        checkOutput("rst.result", int'(result1), 0);
        checkOutput("rst.at_min", int'(at_min1), 1);
        checkOutput("rst.at_max", int'(at_max1), 0);
        checkOutput("rst.pulses", int'({wrap_pulse1, sat_pulse1}), 0);

        $display("[TB] reset during active count with load");
        applyStimulus(0, 0, 0,    1, 1, 0, 7, 1);
        applyStimulus(0, 0, 0,    1, 1, 0, 7, 1);
        applyStimulus(1, 1, 500,  1, 1, 0, 7, 1);
        checkOutput("rst_mid.result", int'(result1), 0);

        $display("[TB] wrap at range ends");
        applyStimulus(0, 0, 0,    1, 0, 1, 1, 1);
        checkOutput("wrap_dn.result", int'(result1), 2000);
        checkOutput("wrap_dn.at_max", int'(at_max1), 1);
        checkOutput("wrap_dn.pulse",  int'(wrap_pulse1), 1);
        applyStimulus(0, 0, 0,    1, 1, 0, 1, 1);
        checkOutput("wrap_up.result", int'(result1), 0);
        checkOutput("wrap_up.pulse",  int'(wrap_pulse1), 1);
        applyStimulus(0, 0, 0,    0, 0, 0, 1, 1);
        checkOutput("wrap_once.pulse", int'(wrap_pulse1), 0);

        applyStimulus(0, 1, 1998, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0,    1, 1, 0, 5, 1);
        checkOutput("wrap_up5.result", int'(result1), 2);
        applyStimulus(0, 1, 3,    0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0,    1, 0, 1, 5, 1);
        checkOutput("wrap_dn5.result", int'(result1), 1999);

        $display("[TB] saturation");
        applyStimulus(0, 1, 1998, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0,    1, 1, 0, 5, 0);
        checkOutput("sat1.result", int'(result1), 2000);
        checkOutput("sat1.pulse",  int'(sat_pulse1), 1);
        applyStimulus(0, 0, 0,    1, 1, 0, 5, 0);
        checkOutput("sat2.result", int'(result1), 2000);
        checkOutput("sat2.pulse",  int'(sat_pulse1), 1);
        applyStimulus(0, 0, 0,    1, 0, 1, 0, 0);
        checkOutput("step0.result", int'(result1), 2000);
        checkOutput("step0.pulses", int'({wrap_pulse1, sat_pulse1}), 0);

        $display("[TB] load priority and clamping");
        // 3000 is not encodable on 11 bits; the largest code exercises the
        // same upper clamp.
        applyStimulus(0, 1, 2047, 1, 1, 0, 3, 0);
        checkOutput("ld_clamp.result", int'(result1), 2000);
        checkOutput("ld_clamp.sat",    int'(sat_pulse1), 1);
        applyStimulus(0, 1, 150,  0, 0, 0, 0, 0);
        checkOutput("ld150.result", int'(result1), 150);
        checkOutput("ld150.sat",    int'(sat_pulse1), 0);

        $display("[TB] hold cases");
        applyStimulus(0, 0, 0,    1, 1, 1, 4, 0);
        checkOutput("both.result", int'(result1), 150);
        applyStimulus(0, 0, 0,    0, 1, 0, 4, 0);
        checkOutput("en0.result", int'(result1), 150);

        $display("[TB] narrow range step clamp");
        applyStimulus(0, 1, 12,   0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0,    1, 1, 0, 15, 1);
        checkOutput("narrow_up.result", int'(result2), 12);
        checkOutput("narrow_up.wrap",   int'(wrap_pulse2), 1);
        applyStimulus(0, 0, 0,    1, 0, 1, 15, 1);
        checkOutput("narrow_dn.result", int'(result2), 12);
        checkOutput("narrow_dn.wrap",   int'(wrap_pulse2), 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       lv = 0;
                1:       lv = 9;
                2:       lv = 10;
                3:       lv = 20;
                4:       lv = 21;
                5:       lv = 1999;
                6:       lv = 2000;
                7:       lv = 2001 + int'($urandom_range(0, 46));
                default: lv = int'($urandom_range(0, 2047));
            endcase
            rst = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            applyStimulus(rst, ld, lv,
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
